// File: rtl/otg_hpi_pkg.sv
// Shared types and register map for the CY7C67200 HPI transfer sequencer.
package otg_hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } hpi_state_e;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CMD    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_DONE_BIT = 1;
  localparam int unsigned STAT_INT_BIT  = 2;
  localparam int unsigned STAT_ERR_BIT  = 3;

  localparam int unsigned CTRL_RST_BIT  = 0;
  localparam int unsigned CTRL_IE_BIT   = 1;

  localparam int unsigned CMD_READ_BIT  = 2;

endpackage

// File: rtl/otg_hpi_sync.sv
// Two-flop synchronizer for the asynchronous OTG interrupt line.
module otg_hpi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[0], async_i};
    end
  end

  assign sync_o = ff_q[1];

endmodule

// File: rtl/otg_hpi_ctrl.sv
// Avalon-MM slave sequencing single 16-bit HPI transfers to a CY7C67200.
// Optional CPU interrupt enabled by defining OTG_HPI_CTRL_IRQ_EN.
module otg_hpi_ctrl
  import otg_hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned RECOV_CYC  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  otg_addr,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic        otg_rst_n,
  input  logic        otg_int,
  output logic        irq
);

  localparam int unsigned CW = 8;

  hpi_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic        rd_dir_q;
  logic        done_q, err_q;
  logic [15:0] tx_q, rx_q;
  logic [31:0] readdata_q, rdata_d;
  logic [1:0]  hpi_addr_q;
  logic [15:0] data_out_q;
  logic        oe_q, cs_n_q, rd_n_q, wr_n_q, otg_rst_n_q;
  logic        int_sync, ctrl_ie;
  logic        bus_wr, bus_rd, busy;
  logic        unused_wdata;

  assign bus_wr       = chipselect & ~write_n;
  assign bus_rd       = chipselect & ~read_n;
  assign busy         = (state_q != ST_IDLE);
  assign unused_wdata = ^writedata[31:16];

  otg_hpi_sync u_int_sync (
    .clk    (clk),
    .rst_n  (reset_n),
    .async_i(otg_int),
    .sync_o (int_sync)
  );

  always_comb begin
    rdata_d = '0;
    case (address)
      REG_DATA:   rdata_d[15:0] = rx_q;
      REG_STATUS: begin
        rdata_d[STAT_BUSY_BIT] = busy;
        rdata_d[STAT_DONE_BIT] = done_q;
        rdata_d[STAT_INT_BIT]  = int_sync;
        rdata_d[STAT_ERR_BIT]  = err_q;
      end
      REG_CTRL: begin
        rdata_d[CTRL_RST_BIT] = ~otg_rst_n_q;
        rdata_d[CTRL_IE_BIT]  = ctrl_ie;
      end
      default: rdata_d = '0;
    endcase
  end

  // Sticky-bit sets are written after the clears so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_dir_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rx_q       <= '0;
      hpi_addr_q <= '0;
      data_out_q <= '0;
      oe_q       <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
    end else begin
      if (bus_wr && address == REG_STATUS) begin
        if (writedata[STAT_DONE_BIT]) done_q <= 1'b0;
        if (writedata[STAT_ERR_BIT])  err_q  <= 1'b0;
      end
      if (bus_wr && busy && (address == REG_CMD || address == REG_DATA)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus_wr && address == REG_CMD) begin
            hpi_addr_q <= writedata[1:0];
            rd_dir_q   <= writedata[CMD_READ_BIT];
            oe_q       <= ~writedata[CMD_READ_BIT];
            data_out_q <= tx_q;
            cs_n_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= CW'(SETUP_CYC - 1);
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            rd_n_q  <= ~rd_dir_q;
            wr_n_q  <= rd_dir_q;
            cnt_q   <= CW'(STROBE_CYC - 1);
            state_q <= ST_STROBE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            if (rd_dir_q) rx_q <= otg_data_in;
            cnt_q   <= CW'(HOLD_CYC - 1);
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            cs_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            cnt_q   <= CW'(RECOV_CYC - 1);
            state_q <= ST_RECOVER;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RECOVER: begin
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q  <= '0;
      tx_q        <= '0;
      otg_rst_n_q <= 1'b1;
    end else begin
      if (bus_rd) readdata_q <= rdata_d;
      if (bus_wr && !busy && address == REG_DATA) tx_q <= writedata[15:0];
      if (bus_wr && address == REG_CTRL) otg_rst_n_q <= ~writedata[CTRL_RST_BIT];
    end
  end

`ifdef OTG_HPI_CTRL_IRQ_EN
  logic ctrl_ie_q, irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_ie_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (bus_wr && address == REG_CTRL) ctrl_ie_q <= writedata[CTRL_IE_BIT];
      irq_q <= ctrl_ie_q & (done_q | int_sync);
    end
  end

  assign ctrl_ie = ctrl_ie_q;
  assign irq     = irq_q;
`else
  assign ctrl_ie = 1'b0;
  assign irq     = 1'b0;
`endif

  assign readdata     = readdata_q;
  assign otg_addr     = hpi_addr_q;
  assign otg_data_out = data_out_q;
  assign otg_data_oe  = oe_q;
  assign otg_cs_n     = cs_n_q;
  assign otg_rd_n     = rd_n_q;
  assign otg_wr_n     = wr_n_q;
  assign otg_rst_n    = otg_rst_n_q;

endmodule

// File: tb/tb_otg_hpi_ctrl.sv
// Randomized self-checking bench for otg_hpi_ctrl against a cycle-position model.
module tb_otg_hpi_ctrl;

  localparam int S  = 2;
  localparam int ST = 4;
  localparam int H  = 1;
  localparam int R  = 4;
  localparam int T  = S + ST + H + R;

  localparam logic [1:0] A_DATA = 2'd0, A_CMD = 2'd1, A_STAT = 2'd2, A_CTRL = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, read_n, write_n;
  logic [31:0] writedata, readdata;
  logic [1:0]  otg_addr;
  logic [15:0] otg_data_out, otg_data_in;
  logic        otg_data_oe, otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n, otg_int, irq;

  int checks = 0;
  int errors = 0;

  logic [15:0] tx_m, rx_m;
  bit          done_m, err_m, rst_m, ie_m;

  always #5 clk = ~clk;

  otg_hpi_ctrl #(
    .SETUP_CYC (S),
    .STROBE_CYC(ST),
    .HOLD_CYC  (H),
    .RECOV_CYC (R)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .read_n      (read_n),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .otg_addr    (otg_addr),
    .otg_data_out(otg_data_out),
    .otg_data_oe (otg_data_oe),
    .otg_data_in (otg_data_in),
    .otg_cs_n    (otg_cs_n),
    .otg_rd_n    (otg_rd_n),
    .otg_wr_n    (otg_wr_n),
    .otg_rst_n   (otg_rst_n),
    .otg_int     (otg_int),
    .irq         (irq)
  );

  task automatic idle_bus();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = d;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = a;
    @(negedge clk);
    d = readdata;
    idle_bus();
  endtask

  function automatic logic [31:0] status_m(input bit busy);
    logic [31:0] v;
    v = '0;
    v[0] = busy; v[1] = done_m; v[2] = otg_int; v[3] = err_m;
    return v;
  endfunction

  function automatic logic [31:0] ctrl_m();
    logic [31:0] v;
    v = '0;
    v[0] = rst_m; v[1] = ie_m;
    return v;
  endfunction

  task automatic reset_model();
    tx_m = '0; rx_m = '0; done_m = 0; err_m = 0; rst_m = 0; ie_m = 0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset_n = 1'b0; otg_int = 1'b0; otg_data_in = '0; address = '0; writedata = '0;
    idle_bus();
    reset_model();
    repeat (3) @(negedge clk);
    checks++;
    if ({otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe, otg_rst_n, irq} !== 6'b111010)
      $display("FAIL reset_pins: got %b want 111010",
               {otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe, otg_rst_n, irq});
    checks++;
    if ({readdata, otg_addr, otg_data_out} !== '0)
      $display("FAIL reset_regs: readdata %h addr %h data_out %h want 0", readdata, otg_addr, otg_data_out);
    reset_n = 1'b1;
    for (int unsigned a = 0; a < 4; a++) begin
      bus_read(a[1:0], r);
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL reset_read[%0d]: got %h want 0", a, r); end
    end
  endtask

  // coll: 0 none, 1 CMD write while busy, 2 DATA write while busy
  task automatic run_xfer(input bit is_rd, input logic [1:0] ha, input int coll, input bit load_tx);
    logic [31:0] w, exp_st, r;
    logic [15:0] cap;
    logic [3:0]  exp_pins, got_pins;
    bit          csl, stb;
    cap = rx_m;
    if (!is_rd && load_tx) begin
      w = $urandom;
      bus_write(A_DATA, w);
      tx_m = w[15:0];
    end
    @(negedge clk);
    w = $urandom; w[2] = is_rd; w[1:0] = ha;
    chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = A_CMD; writedata = w;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      csl = (i < S + ST + H);
      stb = (i >= S) && (i < S + ST);
      exp_pins = {!csl, !(is_rd && stb), !(!is_rd && stb), !is_rd && csl};
      got_pins = {otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe};
      checks++;
      if (got_pins !== exp_pins) begin
        errors++; $display("FAIL pins cyc%0d: cs/rd/wr/oe got %b want %b", i, got_pins, exp_pins);
      end
      if (csl) begin
        checks++;
        if (otg_addr !== ha) begin errors++; $display("FAIL hpi_addr cyc%0d: got %0d want %0d", i, otg_addr, ha); end
        if (!is_rd) begin
          checks++;
          if (otg_data_out !== tx_m) begin
            errors++; $display("FAIL hpi_wdata cyc%0d: got %h want %h", i, otg_data_out, tx_m);
          end
        end
      end
      if (i >= 1 && !(coll != 0 && i == 3)) begin
        exp_st = '0;
        exp_st[0] = (i <= T);
        exp_st[1] = (i > T);
        exp_st[3] = err_m | (coll != 0 && i >= 4);
        checks++;
        if (readdata !== exp_st) begin
          errors++; $display("FAIL status cyc%0d: got %h want %h", i, readdata, exp_st);
        end
      end
      otg_data_in = 16'($urandom);
      if (i == S + ST - 1) cap = otg_data_in;
      if (coll != 0 && i == 2) begin
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1;
        address = (coll == 1) ? A_CMD : A_DATA; writedata = $urandom;
      end else begin
        chipselect = 1'b1; write_n = 1'b1; read_n = 1'b0; address = A_STAT;
      end
    end
    idle_bus();
    done_m = 1;
    if (coll != 0) err_m = 1;
    if (is_rd) rx_m = cap;
    bus_read(A_DATA, r);
    checks++;
    if (r !== {16'h0, rx_m}) begin errors++; $display("FAIL data_read: got %h want %h", r, {16'h0, rx_m}); end
    checks++;
    if (irq !== (ie_m & done_m)) begin errors++; $display("FAIL irq_after_xfer: got %b want %b", irq, ie_m & done_m); end
  endtask

  task automatic test_write_read();
    otg_data_in = 16'hBEEF;
    run_xfer(1'b0, 2'd1, 0, 1'b1);
    run_xfer(1'b1, 2'd2, 0, 1'b0);
  endtask

  task automatic test_status_clear();
    logic [31:0] r;
    bus_read(A_STAT, r);
    checks++;
    if (r !== status_m(0)) begin errors++; $display("FAIL status_pre: got %h want %h", r, status_m(0)); end
    bus_write(A_STAT, 32'h8); err_m = 0;
    bus_read(A_STAT, r);
    checks++;
    if (r !== status_m(0)) begin errors++; $display("FAIL status_clr_err: got %h want %h", r, status_m(0)); end
    bus_write(A_STAT, 32'h2); done_m = 0;
    bus_read(A_STAT, r);
    checks++;
    if (r !== status_m(0)) begin errors++; $display("FAIL status_clr_done: got %h want %h", r, status_m(0)); end
  endtask

  task automatic test_collision();
    run_xfer(1'b0, 2'($urandom), 1, 1'b1);
    test_status_clear();
    run_xfer(1'b1, 2'($urandom), 2, 1'b0);
    run_xfer(1'b0, 2'($urandom), 0, 1'b0);
    test_status_clear();
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      run_xfer(1'($urandom), 2'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
      if (($urandom & 1) != 0) test_status_clear();
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] r;
    int          seen_cs;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = A_CMD; writedata = 32'h6;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; read_n = 1'b0; address = A_STAT;
    repeat (S) @(negedge clk);
    checks++;
    if (otg_rd_n !== 1'b0) begin errors++; $display("FAIL midrst_in_strobe: rd_n got %b want 0", otg_rd_n); end
    idle_bus();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe} !== 4'b1110) begin
      errors++; $display("FAIL midrst_pins: got %b want 1110", {otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe});
    end
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL midrst_readdata: got %h want 0", readdata); end
    reset_model();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen_cs = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (otg_cs_n !== 1'b1) seen_cs++;
    end
    checks++;
    if (seen_cs != 0) begin errors++; $display("FAIL midrst_idle: cs_n low %0d cycles want 0", seen_cs); end
    bus_read(A_STAT, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL midrst_status: got %h want 0", r); end
    run_xfer(1'b0, 2'd3, 0, 1'b1);
  endtask

  task automatic test_chip_reset();
    logic [31:0] w, r;
    for (int n = 0; n < 5; n++) begin
      w = (n == 0) ? 32'h1 : (n == 4) ? 32'h0 : $urandom;
      bus_write(A_CTRL, w);
      rst_m = w[0];
`ifdef OTG_HPI_CTRL_IRQ_EN
      ie_m = w[1];
`endif
      checks++;
      if (otg_rst_n !== !rst_m) begin errors++; $display("FAIL chip_rst[%0d]: got %b want %b", n, otg_rst_n, !rst_m); end
      bus_read(A_CTRL, r);
      checks++;
      if (r !== ctrl_m()) begin errors++; $display("FAIL ctrl_read[%0d]: got %h want %h", n, r, ctrl_m()); end
    end
  endtask

  task automatic test_irq();
    bit exp_b;
    bus_write(A_STAT, 32'hA); done_m = 0; err_m = 0;
    bus_write(A_CTRL, 32'h2);
    rst_m = 0;
`ifdef OTG_HPI_CTRL_IRQ_EN
    ie_m = 1;
`endif
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_quiet: got %b want 0", irq); end
    otg_int = 1'b1;
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = A_STAT;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_b = (k >= 3);
      checks++;
      if (readdata[2] !== exp_b) begin errors++; $display("FAIL int_sync k%0d: got %b want %b", k, readdata[2], exp_b); end
      checks++;
      if (irq !== (exp_b & ie_m)) begin errors++; $display("FAIL irq_int k%0d: got %b want %b", k, irq, exp_b & ie_m); end
    end
    idle_bus();
    bus_write(A_CTRL, 32'h0); ie_m = 0;
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable: got %b want 0", irq); end
    otg_int = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_status_clear();
    test_collision();
    test_chip_reset();
    test_irq();
    bus_write(A_CTRL, 32'h2);
`ifdef OTG_HPI_CTRL_IRQ_EN
    ie_m = 1;
`endif
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want finish before 2ms");
    $fatal(1);
  end

endmodule

// File: doc/otg_hpi_ctrl.md
# otg_hpi_ctrl

Avalon-MM slave that sequences single 16-bit transfers on the CY7C67200 host-port interface (HPI). It replaces software bit-banging of the separate HPI data/address/strobe PIOs. Software loads a data word and posts one command. The block then generates the chip-select, read/write strobe and address phases with programmable cycle counts, captures read data, and reports completion through a status register and an optional interrupt. It sits between the Nios II Avalon fabric and the top-level OTG pins.

## Interface
Parameters:
- SETUP_CYC, 2, cycles from cs_n/address asserted to strobe asserted (≥1)
- STROBE_CYC, 4, cycles rd_n/wr_n held low (≥1)
- HOLD_CYC, 1, cycles after strobe release with cs_n still low (≥1)
- RECOV_CYC, 4, cycles with cs_n high before idle (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select: 0 DATA, 1 CMD, 2 STATUS, 3 CTRL
- chipselect  in  1  slave select
- read_n  in  1  active-low read
- write_n  in  1  active-low write
- writedata  in  32  write data
- readdata  out  32  registered read data
- otg_addr  out  2  HPI address
- otg_data_out  out  16  HPI write data
- otg_data_oe  out  1  HPI data-bus drive enable, for the top-level tri-state
- otg_data_in  in  16  HPI read data
- otg_cs_n, otg_rd_n, otg_wr_n  out  1  HPI strobes, active-low
- otg_rst_n  out  1  OTG chip reset
- otg_int  in  1  asynchronous OTG interrupt
- irq  out  1  interrupt to CPU

## Operation
Registers:
- DATA (address 0)
  - Write bits [15:0] = transmit word.
  - Read returns the last captured HPI read word, zero-extended.
- CMD (address 1): a write starts a transfer.
  - Bits [1:0] = HPI address.
  - Bit 2: 1 = read, 0 = write.
- STATUS (address 2)
  - bit0 busy.
  - bit1 done: sticky, set on return to IDLE.
  - bit2 otg_int, synchronized.
  - bit3 err: sticky, set by a CMD or DATA write while busy.
  - Writing 1 to bit1 or bit3 clears that bit. If a set and a clear occur in the same cycle, set wins.
- CTRL (address 3)
  - bit0 = chip reset: 1 drives otg_rst_n low.
  - bit1 = irq enable.

FSM states IDLE → SETUP → STROBE → HOLD → RECOVER → IDLE. Each non-idle state lasts exactly its parameter count, measured with a shared down-counter.
- IDLE: a CMD write with busy=0 latches the address and direction and clears done; the next state is SETUP. A CMD write while busy is ignored and sets err. A DATA write while busy is ignored and sets err.
- SETUP: cs_n=0, otg_addr valid. For writes, oe=1 and otg_data_out=DATA.
- STROBE: rd_n=0 for a read, wr_n=0 for a write. Read data is captured into DATA on the final STROBE cycle edge.
- HOLD: strobe=1, cs_n=0. Address and write data remain driven.
- RECOVER: cs_n=1, oe=0.

Reset values: readdata 0, otg_addr 0, otg_data_out 0, otg_data_oe 0, otg_cs_n/rd_n/wr_n 1, otg_rst_n 1, irq 0, all registers 0, state IDLE. Asserting reset mid-transfer releases all strobes immediately and returns the FSM to IDLE.

## Timing
- readdata is registered: it is valid one clk after the read access. Reads have no waitrequest.
- A CMD write at edge N gives state SETUP from N+1. otg_cs_n falls at N+1. The strobe asserts at N+1+SETUP_CYC.
- busy stays high for SETUP_CYC+STROBE_CYC+HOLD_CYC+RECOV_CYC cycles (11 with defaults). done is set at the edge entering IDLE.
- otg_int passes through a 2-flop synchronizer, giving 2 cycles of latency to STATUS bit2.
- All HPI outputs are driven directly from flops and are glitch-free.

## Configuration
- OTG_HPI_CTRL_IRQ_EN defined: irq = CTRL.bit1 & (STATUS.done | otg_int_sync). irq is registered and has 1 cycle of latency.
- Not defined: irq is tied to 0. CTRL bit1 is not stored and reads 0.

## Structure
- Package otg_hpi_pkg holds:
  - the state enum;
  - register offsets (REG_DATA=0, REG_CMD=1, REG_STATUS=2, REG_CTRL=3);
  - STATUS/CTRL/CMD bit-position constants.
- Sub-module otg_hpi_sync: a 2-flop synchronizer for otg_int, with async reset to 0.

## Test plan
- Write: DATA←0x1234, CMD←0x1 (addr 1, write). Required: cs_n low for exactly 7 cycles, wr_n low for exactly 4 cycles, otg_data_out=0x1234 and otg_addr=1 throughout, rd_n stays high. STATUS reads 0x2 after 11 cycles.
- Read: otg_data_in=0xBEEF, CMD←0x6 (addr 2, read). Required: rd_n low for 4 cycles, oe=0 throughout. DATA reads 0x0000BEEF afterwards.
- Busy collision: issue a second CMD write 3 cycles into a transfer. Required: no second transfer occurs, STATUS=0x9 while busy, then 0xA. Writing 0x8 to STATUS gives 0x2.
- Mid-transfer reset: assert reset_n during STROBE. Required: cs_n, rd_n and wr_n are 1 and oe is 0 in the same cycle, readdata is 0, and the FSM is in IDLE after release.
- Interrupt (OTG_HPI_CTRL_IRQ_EN defined): CTRL←0x2, then raise otg_int. Required: STATUS bit2 set within 2 cycles, irq high 1 cycle later. Set CTRL bit1=0: irq=0.
- Chip reset: CTRL←0x1. Required: otg_rst_n=0. CTRL←0x0: otg_rst_n=1.
